// File: rtl/io881_mem_pkg.sv
// Shared types and widths for the ifetch-side program SRAM responder.
// Address layout is {channel[14:12], pc[11:0]}.
package io881_mem_pkg;

  localparam int ADDR_W   = 15;
  localparam int DATA_W   = 8;
  localparam int CHAN_MSB = 14;
  localparam int CHAN_LSB = 12;
  localparam int PC_W     = 12;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_WAIT = 3'd3,
    ST_ACK  = 3'd4,
    ST_WR   = 3'd5
  } mem_state_e;

endpackage

// File: rtl/ifetch_mem_responder.sv
// One-outstanding-read SRAM responder for ifetch plus a host write port; read ack
// lands 2+WAIT_STATES cycles after acceptance, host write acks in one cycle.
module ifetch_mem_responder
  import io881_mem_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mem_rd_en,
  input  logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_d_in,
  output logic              mem_ack,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_d,
  output logic              host_ack,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_rd,
  output logic              sram_we,
  output logic [DATA_W-1:0] sram_d,
  input  logic [DATA_W-1:0] sram_q
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES != 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  mem_state_e        state_q, state_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdat_q, wdat_d;
  logic [DATA_W-1:0] cap_q, cap_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              req_lost;

  // The latched address doubles as the SRAM address and the abort reference.
  assign req_lost = !mem_rd_en || (mem_addr != addr_q);

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    cap_d   = cap_q;
    dout_d  = dout_q;
    unique case (state_q)
      ST_IDLE: begin
        if (host_we) begin
          state_d = ST_WR;
          addr_d  = host_addr;
          wdat_d  = host_d;
        end else if (mem_rd_en) begin
          state_d = ST_RD;
          addr_d  = mem_addr;
        end
      end
      ST_RD: begin
        state_d = req_lost ? ST_IDLE : ST_CAP;
      end
      ST_CAP: begin
        if (req_lost) begin
          state_d = ST_IDLE;
        end else begin
          cap_d = sram_q;
          if (WAIT_STATES != 0) begin
            state_d = ST_WAIT;
            wcnt_d  = WAIT_LOAD;
          end else begin
            state_d = ST_ACK;
            dout_d  = sram_q;
          end
        end
      end
      ST_WAIT: begin
        if (req_lost) begin
          state_d = ST_IDLE;
        end else if (wcnt_q == 4'd0) begin
          state_d = ST_ACK;
          dout_d  = cap_q;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      // ifetch moves its address on the edge leaving ACK, so never accept here.
      ST_ACK:  state_d = ST_IDLE;
      ST_WR:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      wcnt_q  <= 4'd0;
      addr_q  <= '0;
      wdat_q  <= '0;
      cap_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      cap_q   <= cap_d;
      dout_q  <= dout_d;
    end
  end

  assign mem_ack   = (state_q == ST_ACK);
  assign host_ack  = (state_q == ST_WR);
  assign sram_rd   = (state_q == ST_RD);
  assign sram_we   = (state_q == ST_WR);
  assign mem_d_in  = dout_q;
  assign sram_addr = addr_q;
  assign sram_d    = wdat_q;

endmodule
